// File: rtl/rtc_timer_wb.sv
// Wishbone RTC/timer: prescaled sub-second tick, 32-bit seconds, periodic irq, N seconds-compare alarms.
// Latency: bus ack one cycle after cyc&stb; counters update on the tick edge; int_o one cycle after status/ctrl.
// Backpressure: none; one access per two cycles (ack deasserts for a cycle before the next access is taken).
module rtc_timer_wb #(
    parameter int DIV     = 100,
    parameter int SUBSEC  = 100,
    parameter int N_ALARM = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        int_o
);

    localparam int SW = $clog2(SUBSEC);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [SW-1:0] SUB_MAX   = SW'(SUBSEC - 1);

    localparam logic [5:0] A_SEC  = 6'h00;
    localparam logic [5:0] A_SUB  = 6'h01;
    localparam logic [5:0] A_CTRL = 6'h02;
    localparam logic [5:0] A_STAT = 6'h03;
    localparam logic [5:0] A_PER  = 6'h04;

    // state
    logic [PW-1:0]      presc_q,  presc_d;
    logic [SW-1:0]      subsec_q, subsec_d;
    logic [SW-1:0]      shadow_q, shadow_d;
    logic [31:0]        sec_q,    sec_d;
    logic               run_q,    run_d;
    logic               pie_q,    pie_d;
    logic [N_ALARM-1:0] aie_q,    aie_d;
    logic               pp_q,     pp_d;
    logic [N_ALARM-1:0] ap_q,     ap_d;
    logic [15:0]        period_q, period_d;
    logic [15:0]        pcnt_q,   pcnt_d;
    logic [31:0]        alarm_q [N_ALARM];
    logic [31:0]        alarm_d [N_ALARM];
    logic               ack_q,    ack_d;
    logic [31:0]        dat_q,    dat_d;
    logic               int_q,    int_d;

    // decode and events
    logic [5:0]         word;
    logic               acc, wr, rd;
    logic               tick, roll;
    logic               sec_wr, per_wr, ctrl_wr, stat_wr, alarm_wr;
    logic               pp_set;
    logic [N_ALARM-1:0] ap_set;
    logic [31:0]        sec_inc;
    logic [31:0]        rdata;
    logic               unused_adr;

    assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

    assign word     = wb_adr_i[7:2];
    assign acc      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr       = acc & wb_we_i;
    assign rd       = acc & ~wb_we_i;
    assign sec_wr   = wr && (word == A_SEC);
    assign ctrl_wr  = wr && (word == A_CTRL);
    assign stat_wr  = wr && (word == A_STAT);
    assign per_wr   = wr && (word == A_PER);
    assign alarm_wr = wr && (word[5:3] == 3'b001);

    assign tick     = run_q && (presc_q == PRESC_MAX);
    assign roll     = tick && (subsec_q == SUB_MAX);
    assign sec_inc  = sec_q + 32'd1;
    assign pp_set   = tick && (period_q != 16'd0) && (pcnt_q == period_q - 16'd1);

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    // Time base, periodic counter, alarms, status and register writes.
    always_comb begin
        presc_d  = presc_q;
        subsec_d = subsec_q;
        sec_d    = sec_q;
        run_d    = run_q;
        pie_d    = pie_q;
        aie_d    = aie_q;
        period_d = period_q;
        pcnt_d   = pcnt_q;
        alarm_d  = alarm_q;
        ap_set   = '0;

        if (run_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            subsec_d = roll ? '0 : subsec_q + 1'b1;
        end
        if (roll) begin
            sec_d = sec_inc;
        end
        // A software SECONDS write overrides a coincident rollover and restarts the second.
        if (sec_wr) begin
            sec_d    = lane_merge(sec_q, wb_dat_i, wb_sel_i);
            presc_d  = '0;
            subsec_d = '0;
        end

        // Alarms only fire on a counted advance, never on a software write.
        for (int k = 0; k < N_ALARM; k++) begin
            ap_set[k] = roll && !sec_wr && (sec_inc == alarm_q[k]);
        end

        if (period_q == 16'd0) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = pp_set ? 16'd0 : pcnt_q + 16'd1;
        end
        if (per_wr) begin
            period_d = {wb_sel_i[1] ? wb_dat_i[15:8] : period_q[15:8],
                        wb_sel_i[0] ? wb_dat_i[7:0]  : period_q[7:0]};
            pcnt_d   = '0;
        end

        if (ctrl_wr && wb_sel_i[0]) begin
            run_d = wb_dat_i[0];
            pie_d = wb_dat_i[1];
        end
        if (ctrl_wr && wb_sel_i[1]) begin
            aie_d = wb_dat_i[8 +: N_ALARM];
        end

        for (int k = 0; k < N_ALARM; k++) begin
            if (alarm_wr && (word[2:0] == 3'(k))) begin
                alarm_d[k] = lane_merge(alarm_q[k], wb_dat_i, wb_sel_i);
            end
        end

        // W1C clear loses to a same-cycle hardware set.
        pp_d = (pp_q & ~(stat_wr & wb_sel_i[0] & wb_dat_i[0])) | pp_set;
        ap_d = (ap_q & ~((stat_wr & wb_sel_i[1]) ? wb_dat_i[8 +: N_ALARM] : '0)) | ap_set;
    end

    // Read data mux, SUBSEC shadow capture, ack and interrupt next-state.
    always_comb begin
        rdata = '0;
        case (word)
            A_SEC:   rdata = sec_q;
            A_SUB:   rdata = 32'(shadow_q);
            A_CTRL: begin
                rdata[0]             = run_q;
                rdata[1]             = pie_q;
                rdata[8 +: N_ALARM]  = aie_q;
            end
            A_STAT: begin
                rdata[0]             = pp_q;
                rdata[8 +: N_ALARM]  = ap_q;
            end
            A_PER:   rdata = {16'd0, period_q};
            default: begin
                for (int k = 0; k < N_ALARM; k++) begin
                    if ((word[5:3] == 3'b001) && (word[2:0] == 3'(k))) begin
                        rdata = alarm_q[k];
                    end
                end
            end
        endcase

        dat_d    = rd ? rdata : dat_q;
        shadow_d = (rd && (word == A_SEC)) ? subsec_q : shadow_q;
        ack_d    = acc;
        int_d    = (pp_q & pie_q) | (|(ap_q & aie_q));
    end

    // State register; async reset puts everything, including a pending ack, to its reset value.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            presc_q  <= '0;
            subsec_q <= '0;
            shadow_q <= '0;
            sec_q    <= '0;
            run_q    <= 1'b1;
            pie_q    <= 1'b0;
            aie_q    <= '0;
            pp_q     <= 1'b0;
            ap_q     <= '0;
            period_q <= '0;
            pcnt_q   <= '0;
            for (int k = 0; k < N_ALARM; k++) begin
                alarm_q[k] <= '0;
            end
            ack_q    <= 1'b0;
            dat_q    <= '0;
            int_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            subsec_q <= subsec_d;
            shadow_q <= shadow_d;
            sec_q    <= sec_d;
            run_q    <= run_d;
            pie_q    <= pie_d;
            aie_q    <= aie_d;
            pp_q     <= pp_d;
            ap_q     <= ap_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            alarm_q  <= alarm_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            int_q    <= int_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign int_o    = int_q;

endmodule

// File: tb/tb_rtc_timer_wb.sv
// Bench for rtc_timer_wb with DIV=4, SUBSEC=10 (40 clocks per second).
// Latency: edge counts below are relative to reset release; every bus access spans two edges.
// Backpressure: none; the bench waits a bounded number of cycles for each ack.
module tb_rtc_timer_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int e_cnt = 0;

    always #5 clk = ~clk;

    rtc_timer_wb #(.DIV(4), .SUBSEC(10), .N_ALARM(2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (wdat),
        .wb_dat_o  (rdat),
        .wb_we_i   (we),
        .wb_sel_i  (sel),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_ack_o  (ack),
        .int_o     (irq)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.sel = s; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: capture edge is e_cnt+1, then one idle edge while ack drops.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic irq_at_ack);
        int lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 4);
        check("ack_latency", 32'(lat), 32'd1);
        rd = rdat;
        irq_at_ack = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_single", 32'(ack), 32'd0);
        e_cnt += lat + 1;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        logic        ia;
        bus(1'b0, a, 32'd0, 4'hF, v, ia);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        logic        ia;
        bus(1'b1, a, d, s, v, ia);
    endtask

    task automatic run_to(input int target);
        while (e_cnt < target) begin
            @(posedge clk);
            e_cnt++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic        ia;

        tbl[0]  = mk(1'b0, 32'h00, 32'h0,        4'hF, 32'h0);
        tbl[1]  = mk(1'b0, 32'h04, 32'h0,        4'hF, 32'h0);
        tbl[2]  = mk(1'b0, 32'h08, 32'h0,        4'hF, 32'h1);
        tbl[3]  = mk(1'b0, 32'h0C, 32'h0,        4'hF, 32'h0);
        tbl[4]  = mk(1'b0, 32'h10, 32'h0,        4'hF, 32'h0);
        tbl[5]  = mk(1'b0, 32'h20, 32'h0,        4'hF, 32'h0);
        tbl[6]  = mk(1'b0, 32'h24, 32'h0,        4'hF, 32'h0);
        tbl[7]  = mk(1'b0, 32'h14, 32'h0,        4'hF, 32'h0);
        tbl[8]  = mk(1'b0, 32'h28, 32'h0,        4'hF, 32'h0);
        tbl[9]  = mk(1'b1, 32'h24, 32'hDEADBEEF, 4'hF, 32'h0);
        tbl[10] = mk(1'b0, 32'h24, 32'h0,        4'hF, 32'hDEADBEEF);
        tbl[11] = mk(1'b1, 32'h24, 32'h11223344, 4'h5, 32'h0);
        tbl[12] = mk(1'b0, 32'h24, 32'h0,        4'hF, 32'hDE22BE44);
        tbl[13] = mk(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h0);
        tbl[14] = mk(1'b0, 32'h14, 32'h0,        4'hF, 32'h0);
        tbl[15] = mk(1'b1, 32'h10, 32'hFFFF1234, 4'hF, 32'h0);
        tbl[16] = mk(1'b0, 32'h10, 32'h0,        4'hF, 32'h1234);
        tbl[17] = mk(1'b1, 32'h10, 32'h0,        4'hF, 32'h0);
        tbl[18] = mk(1'b1, 32'h24, 32'h0,        4'hF, 32'h0);
        tbl[19] = mk(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 32'h0);
        tbl[20] = mk(1'b0, 32'h08, 32'h0,        4'hF, 32'h303);
        tbl[21] = mk(1'b1, 32'h08, 32'h1,        4'hF, 32'h0);

        // Reset and release just after an edge so the next edge is edge 1.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        e_cnt = 0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_int", 32'(irq), 32'd0);

        // Register map, reset values, lane merging, unmapped accesses.
        for (int i = 0; i < 22; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, v, ia);
            if (!tbl[i].we) check($sformatf("vec%0d", i), v, tbl[i].exp);
        end
        check("tbl_int", 32'(irq), 32'd0);

        // 400 clocks -> 10 s; coherent SUBSEC via shadow.
        run_to(400);
        rd_chk(32'h00, 32'd10, "sec_400");
        rd_chk(32'h04, 32'd0,  "sub_400");
        rd_chk(32'h00, 32'd10, "sec_404");
        run_to(416);
        rd_chk(32'h04, 32'd1,  "shadow_held");

        // Wrap from all-ones; alarms at 0 pend but stay masked.
        wr(32'h00, 32'hFFFFFFFF, 4'hF);
        run_to(460);
        check("wrap_int", 32'(irq), 32'd0);
        rd_chk(32'h00, 32'd0,     "sec_wrap");
        rd_chk(32'h0C, 32'h300,   "stat_wrap");
        wr(32'h0C, 32'h300, 4'hF);
        wr(32'h00, 32'hAABBCCDD, 4'h2);
        rd_chk(32'h00, 32'h0000CC00, "sec_lane");

        // Alarm 0 at 5 s, seconds restart at edge 475, 5 s reached at edge 675.
        wr(32'h20, 32'd5, 4'hF);
        wr(32'h08, 32'h101, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        run_to(674);
        check("alm_int_pre", 32'(irq), 32'd0);
        run_to(675);
        check("alm_int_same", 32'(irq), 32'd0);
        run_to(676);
        check("alm_int_post", 32'(irq), 32'd1);
        rd_chk(32'h00, 32'd5,    "sec_alarm");
        rd_chk(32'h0C, 32'h100,  "stat_alarm");
        bus(1'b1, 32'h0C, 32'h100, 4'hF, v, ia);
        check("alm_int_at_ack", 32'(ia), 32'd1);
        check("alm_int_clr", 32'(irq), 32'd0);
        wr(32'h00, 32'd5, 4'hF);
        rd_chk(32'h0C, 32'd0, "stat_sw_sec");

        // Periodic: PERIOD=3, PP at edges 699, 711, 723...
        wr(32'h08, 32'h3, 4'hF);
        wr(32'h10, 32'd3, 4'hF);
        run_to(698);
        check("per_int_pre", 32'(irq), 32'd0);
        run_to(700);
        check("per_int_set", 32'(irq), 32'd1);
        wr(32'h0C, 32'h1, 4'hF);
        check("per_int_clr", 32'(irq), 32'd0);
        run_to(710);
        check("per_int_gap", 32'(irq), 32'd0);
        wr(32'h0C, 32'h1, 4'hF);
        check("per_set_wins", 32'(irq), 32'd1);
        rd_chk(32'h0C, 32'h1, "stat_set_wins");
        wr(32'h0C, 32'h1, 4'hF);
        wr(32'h10, 32'd0, 4'hF);
        run_to(748);
        rd_chk(32'h0C, 32'd0, "stat_per_off");
        check("per_off_int", 32'(irq), 32'd0);

        // RUN=0 hold, then resume from held prescaler and periodic count.
        wr(32'h10, 32'd5, 4'hF);
        wr(32'h08, 32'h2, 4'hF);
        run_to(854);
        rd_chk(32'h00, 32'd6, "sec_frozen");
        rd_chk(32'h04, 32'd7, "sub_frozen");
        wr(32'h08, 32'h3, 4'hF);
        run_to(877);
        check("resume_int_pre", 32'(irq), 32'd0);
        run_to(878);
        check("resume_int_set", 32'(irq), 32'd1);
        rd_chk(32'h00, 32'd7, "sec_resume");
        rd_chk(32'h04, 32'd2, "sub_resume");
        wr(32'h0C, 32'h1, 4'hF);
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h08, 32'h1, 4'hF);

        // SECONDS write on the rollover edge 909.
        run_to(908);
        wr(32'h00, 32'h12345678, 4'hF);
        rd_chk(32'h00, 32'h12345678, "sec_wr_roll");
        rd_chk(32'h04, 32'd0,        "sub_wr_roll");

        // Async reset during the ack cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
        @(posedge clk); #1;
        check("arst_ack_pre", 32'(ack), 32'd1);
        check("arst_dat_pre", rdat, 32'h12345678);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_dat", rdat, 32'd0);
        check("arst_int", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        e_cnt = 0;
        rd_chk(32'h08, 32'h1, "arst_ctrl");
        rd_chk(32'h00, 32'd0, "arst_sec");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
